// File: rtl/sdf_bitrev_reorder.sv
// Bit-reversed to natural order reorder buffer for a radix-2^2 SDF FFT output.
// Ping-pong RAM: one bank fills at bitrev(k) while the other drains linearly.
module sdf_bitrev_reorder #(
   parameter int N     = 64,
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             idata_en,
   input  logic [WIDTH-1:0] idata_r,
   input  logic [WIDTH-1:0] idata_i,
   output logic             odata_en,
   output logic [WIDTH-1:0] odata_r,
   output logic [WIDTH-1:0] odata_i,
   output logic             odata_last
);

   localparam int LOG_N = $clog2(N);
   localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

   typedef enum logic {IDLE, READ} state_t;

   function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
      logic [LOG_N-1:0] r;
      for (int b = 0; b < LOG_N; b++) r[b] = a[LOG_N-1-b];
      return r;
   endfunction

   logic [2*WIDTH-1:0] mem [2*N];

   logic [LOG_N-1:0] wr_cnt;
   logic             wr_bank;
   logic             frame_done;
   logic             done_bank;

   state_t           state_q, state_d;
   logic [LOG_N-1:0] rd_cnt, rd_cnt_d;
   logic             rd_bank, rd_bank_d;

   // Write side: any gap in idata_en discards the partial frame.
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_cnt     <= '0;
         wr_bank    <= 1'b0;
         frame_done <= 1'b0;
         done_bank  <= 1'b0;
      end else if (idata_en) begin
         wr_cnt     <= wr_cnt + 1'b1;
         frame_done <= (wr_cnt == LAST);
         done_bank  <= wr_bank;
         if (wr_cnt == LAST) wr_bank <= ~wr_bank;
      end else begin
         wr_cnt     <= '0;
         frame_done <= 1'b0;
      end
   end

   // NOTE: RAM contents are deliberately not reset so the array can map onto block RAM.
   always_ff @(posedge clock) begin
      if (idata_en) mem[{wr_bank, bitrev(wr_cnt)}] <= {idata_r, idata_i};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rd_cnt  <= '0;
         rd_bank <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_cnt  <= rd_cnt_d;
         rd_bank <= rd_bank_d;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = rd_cnt;
      rd_bank_d = rd_bank;
      case (state_q)
         IDLE: begin
            if (frame_done) begin
               state_d   = READ;
               rd_cnt_d  = '0;
               rd_bank_d = done_bank;
            end
         end
         READ: begin
            rd_cnt_d = rd_cnt + 1'b1;
            if (rd_cnt == LAST) begin
               // A frame finishing exactly now chains on with no idle cycle.
               if (frame_done) rd_bank_d = done_bank;
               else            state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         odata_en   <= 1'b0;
         odata_last <= 1'b0;
         odata_r    <= '0;
         odata_i    <= '0;
      end else begin
         odata_en   <= (state_q == READ);
         odata_last <= (state_q == READ) && (rd_cnt == LAST);
         if (state_q == READ) {odata_r, odata_i} <= mem[{rd_bank, rd_cnt}];
      end
   end

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Randomized bench for sdf_bitrev_reorder: a queue model permutes each complete
// input frame into natural order and output bursts are compared against it.
module tb_sdf_bitrev_reorder;

   localparam int N     = 64;
   localparam int W     = 16;
   localparam int LOG_N = 6;

   logic         clock   = 1'b0;
   logic         reset_n = 1'b0;
   logic         idata_en = 1'b0;
   logic [W-1:0] idata_r = '0;
   logic [W-1:0] idata_i = '0;
   logic         odata_en;
   logic [W-1:0] odata_r;
   logic [W-1:0] odata_i;
   logic         odata_last;

   sdf_bitrev_reorder #(.N(N), .WIDTH(W)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .idata_en   (idata_en),
      .idata_r    (idata_r),
      .idata_i    (idata_i),
      .odata_en   (odata_en),
      .odata_r    (odata_r),
      .odata_i    (odata_i),
      .odata_last (odata_last)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2*W-1:0] data;
      logic           last;
      int             cyc;
   } obs_t;

   int             checks = 0;
   int             errors = 0;
   int             cyc    = 0;
   obs_t           obs_q[$];
   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] part_q[$];

   // Output monitor, sampled on the falling edge away from the active edge.
   always @(negedge clock) begin
      cyc++;
      if (odata_en === 1'b1)
         obs_q.push_back('{data: {odata_r, odata_i}, last: odata_last, cyc: cyc});
   end

   function automatic int bitrev(input int k);
      int r = 0;
      for (int b = 0; b < LOG_N; b++) begin
         r = (r << 1) | (k & 1);
         k = k >> 1;
      end
      return r;
   endfunction

   // Drive one input cycle and update the reference model after the edge.
   task automatic drive(input logic en, input logic [W-1:0] r, input logic [W-1:0] i);
      idata_en = en;
      idata_r  = r;
      idata_i  = i;
      @(posedge clock);
      #1;
      if (en) begin
         part_q.push_back({r, i});
         if (part_q.size() == N) begin
            for (int j = 0; j < N; j++) exp_q.push_back(part_q[bitrev(j)]);
            part_q.delete();
         end
      end else begin
         part_q.delete();
      end
      idata_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, W'($urandom), W'($urandom));
   endtask

   task automatic send_random_frame();
      for (int k = 0; k < N; k++) drive(1'b1, W'($urandom), W'($urandom));
   endtask

   task automatic clear_queues();
      obs_q.delete();
      exp_q.delete();
      part_q.delete();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (odata_en !== 1'b0) begin
         errors++; $display("FAIL reset_en: got %b want 0", odata_en);
      end
      checks++;
      if (odata_last !== 1'b0) begin
         errors++; $display("FAIL reset_last: got %b want 0", odata_last);
      end
      checks++;
      if (odata_r !== '0 || odata_i !== '0) begin
         errors++; $display("FAIL reset_data: got %h/%h want 0/0", odata_r, odata_i);
      end
      reset_n = 1'b1;
      idle(N + 10);
      checks++;
      if (obs_q.size() != 0) begin
         errors++; $display("FAIL reset_no_output: got %0d samples want 0", obs_q.size());
      end
      clear_queues();
   endtask

   task automatic test_single_frame();
      int c_first = 0;
      clear_queues();
      for (int k = 0; k < N; k++) begin
         drive(1'b1, W'(bitrev(k)), W'(-bitrev(k)));
         if (k == 0) c_first = cyc + 1;
      end
      idle(N + 4);
      checks++;
      if (obs_q.size() != N) begin
         errors++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), N);
      end else begin
         checks++;
         if (obs_q[0].cyc != c_first + N + 1) begin
            errors++; $display("FAIL single_first_cycle: got %0d want %0d", obs_q[0].cyc, c_first + N + 1);
         end
         checks++;
         if (obs_q[N-1].cyc != c_first + 2*N) begin
            errors++; $display("FAIL single_last_cycle: got %0d want %0d", obs_q[N-1].cyc, c_first + 2*N);
         end
         for (int j = 0; j < N; j++) begin
            checks++;
            if (obs_q[j].data !== {W'(j), W'(-j)} || obs_q[j].last !== (j == N-1)) begin
               errors++;
               $display("FAIL single_sample %0d: got %h last %b want %h last %b",
                        j, obs_q[j].data, obs_q[j].last, {W'(j), W'(-j)}, (j == N-1));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_queues();
      for (int f = 0; f < 3; f++)
         for (int k = 0; k < N; k++)
            drive(1'b1, W'(f*256 + bitrev(k)), W'($urandom));
      idle(N + 4);
      checks++;
      if (obs_q.size() != 3*N) begin
         errors++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), 3*N);
      end else begin
         for (int j = 0; j < 3*N; j++) begin
            checks++;
            if (obs_q[j].cyc != obs_q[0].cyc + j || obs_q[j].data !== exp_q[j] ||
                obs_q[j].data[2*W-1:W] !== W'((j/N)*256 + (j%N)) || obs_q[j].last !== (j%N == N-1)) begin
               errors++;
               $display("FAIL b2b_sample %0d: got %h last %b cyc %0d want %h last %b cyc %0d",
                        j, obs_q[j].data, obs_q[j].last, obs_q[j].cyc, exp_q[j], (j%N == N-1), obs_q[0].cyc + j);
            end
         end
      end
   endtask

   task automatic test_abort();
      clear_queues();
      for (int k = 0; k < 20; k++) drive(1'b1, W'($urandom), W'($urandom));
      idle(3);
      send_random_frame();
      idle(N + 4);
      checks++;
      if (obs_q.size() != N || exp_q.size() != N) begin
         errors++; $display("FAIL abort_count: got %0d want %0d", obs_q.size(), N);
      end else begin
         for (int j = 0; j < N; j++) begin
            checks++;
            if (obs_q[j].data !== exp_q[j] || obs_q[j].last !== (j == N-1)) begin
               errors++;
               $display("FAIL abort_sample %0d: got %h want %h", j, obs_q[j].data, exp_q[j]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_output();
      clear_queues();
      send_random_frame();
      for (int t = 0; t < 4*N && obs_q.size() < 31; t++) begin
         @(negedge clock);
         #2;
      end
      checks++;
      if (obs_q.size() != 31) begin
         errors++; $display("FAIL midrst_reach_index30: got %0d samples want 31", obs_q.size());
      end else begin
         for (int j = 0; j < 31; j++) begin
            checks++;
            if (obs_q[j].data !== exp_q[j]) begin
               errors++; $display("FAIL midrst_pre_sample %0d: got %h want %h", j, obs_q[j].data, exp_q[j]);
            end
         end
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (odata_en !== 1'b0 || odata_last !== 1'b0 || odata_r !== '0 || odata_i !== '0) begin
         errors++;
         $display("FAIL midrst_outputs: got en %b last %b data %h/%h want all 0",
                  odata_en, odata_last, odata_r, odata_i);
      end
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      clear_queues();
      idle(N + 10);
      checks++;
      if (obs_q.size() != 0) begin
         errors++; $display("FAIL midrst_no_output: got %0d samples want 0", obs_q.size());
      end
      clear_queues();
      send_random_frame();
      idle(N + 4);
      checks++;
      if (obs_q.size() != N) begin
         errors++; $display("FAIL midrst_post_count: got %0d want %0d", obs_q.size(), N);
      end else begin
         for (int j = 0; j < N; j++) begin
            checks++;
            if (obs_q[j].data !== exp_q[j] || obs_q[j].last !== (j == N-1)) begin
               errors++; $display("FAIL midrst_post_sample %0d: got %h want %h", j, obs_q[j].data, exp_q[j]);
            end
         end
      end
   endtask

   task automatic test_gap();
      clear_queues();
      send_random_frame();
      idle(7);
      send_random_frame();
      idle(N + 4);
      checks++;
      if (obs_q.size() != 2*N) begin
         errors++; $display("FAIL gap_count: got %0d want %0d", obs_q.size(), 2*N);
      end else begin
         checks++;
         if (obs_q[N].cyc - obs_q[N-1].cyc != 8) begin
            errors++; $display("FAIL gap_idle_cycles: got %0d want 7", obs_q[N].cyc - obs_q[N-1].cyc - 1);
         end
         checks++;
         if (obs_q[N-1].cyc - obs_q[0].cyc != N-1 || obs_q[2*N-1].cyc - obs_q[N].cyc != N-1) begin
            errors++; $display("FAIL gap_burst_len: got %0d/%0d want %0d",
                               obs_q[N-1].cyc - obs_q[0].cyc + 1, obs_q[2*N-1].cyc - obs_q[N].cyc + 1, N);
         end
         for (int j = 0; j < 2*N; j++) begin
            checks++;
            if (obs_q[j].data !== exp_q[j] || obs_q[j].last !== (j%N == N-1)) begin
               errors++; $display("FAIL gap_sample %0d: got %h want %h", j, obs_q[j].data, exp_q[j]);
            end
         end
      end
   endtask

   task automatic test_random_frames();
      clear_queues();
      for (int f = 0; f < 100; f++) begin
         send_random_frame();
         idle($urandom_range(0, 5));
      end
      idle(N + 4);
      checks++;
      if (obs_q.size() != 100*N) begin
         errors++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), 100*N);
      end else begin
         for (int j = 0; j < 100*N; j++) begin
            checks++;
            if (obs_q[j].data !== exp_q[j] || obs_q[j].last !== (j%N == N-1)) begin
               errors++;
               $display("FAIL random_sample %0d: got %h last %b want %h last %b",
                        j, obs_q[j].data, obs_q[j].last, exp_q[j], (j%N == N-1));
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_abort();
      test_reset_mid_output();
      test_gap();
      test_random_frames();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
